req_grant_tracker: RTL and testbench

//   Requester-side companion to the MSB-first priority arbiter. Captures single-cycle

---
 rtl/req_grant_tracker_pkg.sv | 18 +
 rtl/req_grant_tracker_msb_select.sv | 15 +
 rtl/req_grant_tracker.sv | 110 +++++++++++
 tb/tb_req_grant_tracker.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/req_grant_tracker_pkg.sv
// mgpu_arb_pkg: shared constants, FSM state type and one-hot decode helper for the
// request/grant tracker.
package mgpu_arb_pkg;

   localparam int NUM_REQ_DEF = 10;
   localparam int IDX_W_DEF   = $clog2(NUM_REQ_DEF);

   typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_e;

   // Supports vectors up to 32 bits; callers zero-extend.
   function automatic logic [31:0] onehot2idx(input logic [31:0] oh);
      logic [31:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) if (oh[i]) idx = idx | 32'(i);
      return idx;
   endfunction

endpackage

// File: rtl/req_grant_tracker_msb_select.sv
// msb_select: combinational one-hot of the highest set input bit, zero when none set.
module msb_select #(
   parameter int NUM_REQ = 10
) (
   input  logic [NUM_REQ-1:0] in_vec,
   output logic [NUM_REQ-1:0] out_onehot
);

   always_comb begin
      out_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (in_vec[i]) out_onehot = NUM_REQ'(1) << i;
   end

endmodule

// File: rtl/req_grant_tracker.sv
// req_grant_tracker: captures request pulses, offers an MSB-first one-hot grant and
// tracks resource ownership until done. Define RR_MASK_EN for round-robin fairness.
module req_grant_tracker
   import mgpu_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_pulse,
   output logic [NUM_REQ-1:0] gnt_onehot,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid,
   input  logic               gnt_ready,
   input  logic               done,
   output logic               busy,
   output logic [NUM_REQ-1:0] pending
);

   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   pending_q, pending_d;
   logic [NUM_REQ-1:0]   gnt_onehot_q, gnt_onehot_d;
   logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
   logic                 gnt_valid_q, gnt_valid_d;
   logic                 busy_q, busy_d;
   logic [NUM_REQ-1:0]   eligible, sel;
   logic                 accept;

`ifdef RR_MASK_EN
   logic [NUM_REQ-1:0]   mask_q, mask_d;
   logic                 wrap;

   // Every pending client already served: start a fresh rotation.
   assign wrap     = (pending_q & ~mask_q) == '0;
   assign eligible = wrap ? pending_q : (pending_q & ~mask_q);

   always_comb begin
      mask_d = mask_q;
      if (state_q == IDLE && |pending_q && wrap) mask_d = '0;
      if (accept) mask_d = mask_q | gnt_onehot_q;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) mask_q <= '0;
      else        mask_q <= mask_d;
`else
   assign eligible = pending_q;
`endif

   msb_select #(.NUM_REQ(NUM_REQ)) u_msb_select (
      .in_vec     (eligible),
      .out_onehot (sel)
   );

   assign accept = (state_q == OFFER) && gnt_valid_q && gnt_ready;

   always_comb begin
      // A new pulse on the accepted bit survives the clear.
      pending_d    = (pending_q & ~(accept ? gnt_onehot_q : '0)) | req_pulse;
      state_d      = state_q;
      gnt_onehot_d = gnt_onehot_q;
      gnt_idx_d    = gnt_idx_q;
      gnt_valid_d  = gnt_valid_q;
      busy_d       = busy_q;
      case (state_q)
         IDLE: if (|pending_q) begin
            gnt_onehot_d = sel;
            gnt_idx_d    = IDX_W'(onehot2idx(32'(sel)));
            gnt_valid_d  = 1'b1;
            state_d      = OFFER;
         end
         OFFER: if (accept) begin
            gnt_valid_d = 1'b0;
            busy_d      = 1'b1;
            state_d     = BUSY;
         end
         BUSY: if (done) begin
            busy_d       = 1'b0;
            gnt_onehot_d = '0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         gnt_onehot_q <= '0;
         gnt_idx_q    <= '0;
         gnt_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         gnt_onehot_q <= gnt_onehot_d;
         gnt_idx_q    <= gnt_idx_d;
         gnt_valid_q  <= gnt_valid_d;
         busy_q       <= busy_d;
      end

   assign gnt_onehot = gnt_onehot_q;
   assign gnt_idx    = gnt_idx_q;
   assign gnt_valid  = gnt_valid_q;
   assign busy       = busy_q;
   assign pending    = pending_q;

endmodule

// File: tb/tb_req_grant_tracker.sv
// tb_req_grant_tracker: vector table, directed corner sequences and random traffic
// checked against a transaction-level reference model.
module tb_req_grant_tracker;

   localparam int N  = 10;
   localparam int IW = 4;
`ifdef RR_MASK_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [N-1:0]  req_pulse = '0;
   logic          gnt_ready = 1'b0;
   logic          done = 1'b0;
   logic [N-1:0]  gnt_onehot, pending;
   logic [IW-1:0] gnt_idx;
   logic          gnt_valid, busy;

   int checks = 0;
   int failures = 0;

   logic [N-1:0]  m_pend;
   int            m_ph;
   int            m_cur;
   bit            m_served[N];

   typedef struct {
      logic [N-1:0]  req;
      logic          rdy;
      logic          dn;
      logic [N-1:0]  oh;
      logic [IW-1:0] idx;
      logic          v;
      logic          b;
      logic [N-1:0]  pend;
   } vec_t;

   vec_t tbl[7];
   int   got[$];
   int   exp_seq[4];
   bit   prev_busy;

   req_grant_tracker dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_pulse  (req_pulse),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .gnt_valid  (gnt_valid),
      .gnt_ready  (gnt_ready),
      .done       (done),
      .busy       (busy),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = '0;
      m_ph   = 0;
      m_cur  = 0;
      for (int i = 0; i < N; i++) m_served[i] = 1'b0;
   endtask

   // Reference model: phase 0 waiting, 1 offered, 2 owned; m_cur is the chosen client.
   task automatic model_edge(input logic [N-1:0] r, input logic rd, input logic dn);
      logic [N-1:0] np;
      int pick;
      np = m_pend;
      if (m_ph == 1 && rd) np[m_cur] = 1'b0;
      for (int i = 0; i < N; i++) if (r[i]) np[i] = 1'b1;
      if (m_ph == 0) begin
         if (m_pend != '0) begin
            pick = -1;
            for (int i = N - 1; i >= 0; i--)
               if (pick < 0 && m_pend[i] && !(RR && m_served[i])) pick = i;
            if (pick < 0) begin
               for (int i = 0; i < N; i++) m_served[i] = 1'b0;
               for (int i = N - 1; i >= 0; i--) if (pick < 0 && m_pend[i]) pick = i;
            end
            m_cur = pick;
            m_ph  = 1;
         end
      end else if (m_ph == 1) begin
         if (rd) begin
            m_served[m_cur] = 1'b1;
            m_ph = 2;
         end
      end else if (dn) begin
         m_ph = 0;
      end
      m_pend = np;
   endtask

   task automatic compare_all(input string tag);
      int oi;
      check({tag, ".valid"},   32'(gnt_valid), 32'(m_ph == 1));
      check({tag, ".busy"},    32'(busy), 32'(m_ph == 2));
      check({tag, ".onehot"},  32'(gnt_onehot), (m_ph != 0) ? (32'd1 << m_cur) : 32'd0);
      check({tag, ".idx"},     32'(gnt_idx), 32'(m_cur));
      check({tag, ".pending"}, 32'(pending), 32'(m_pend));
      check({tag, ".onehot0"}, 32'($onehot0(gnt_onehot)), 32'd1);
      check({tag, ".idx_rng"}, 32'(gnt_idx < N), 32'd1);
      if (gnt_onehot != '0) begin
         oi = 0;
         for (int i = 0; i < N; i++) if (gnt_onehot[i]) oi = i;
         check({tag, ".idx_match"}, 32'(gnt_idx), 32'(oi));
      end
   endtask

   task automatic step(input logic [N-1:0] r, input logic rd, input logic dn, input string tag);
      req_pulse = r;
      gnt_ready = rd;
      done      = dn;
      @(posedge clk);
      model_edge(r, rd, dn);
      #1;
      compare_all(tag);
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".onehot"},  32'(gnt_onehot), 32'd0);
      check({tag, ".idx"},     32'(gnt_idx), 32'd0);
      check({tag, ".valid"},   32'(gnt_valid), 32'd0);
      check({tag, ".busy"},    32'(busy), 32'd0);
      check({tag, ".pending"}, 32'(pending), 32'd0);
   endtask

   task automatic do_reset(input string tag);
      rst_n     = 1'b0;
      req_pulse = N'($urandom);
      gnt_ready = 1'($urandom);
      done      = 1'($urandom);
      #2;
      check_zero({tag, ".async"});
      @(posedge clk);
      #1;
      check_zero({tag, ".held"});
      model_reset();
      rst_n     = 1'b1;
      req_pulse = '0;
      gnt_ready = 1'b0;
      done      = 1'b0;
   endtask

   initial begin
      tbl[0] = '{10'h088, 1'b1, 1'b0, 10'h000, 4'd0, 1'b0, 1'b0, 10'h088};
      tbl[1] = '{10'h000, 1'b1, 1'b0, 10'h080, 4'd7, 1'b1, 1'b0, 10'h088};
      tbl[2] = '{10'h000, 1'b1, 1'b0, 10'h080, 4'd7, 1'b0, 1'b1, 10'h008};
      tbl[3] = '{10'h000, 1'b0, 1'b1, 10'h000, 4'd7, 1'b0, 1'b0, 10'h008};
      tbl[4] = '{10'h000, 1'b0, 1'b0, 10'h008, 4'd3, 1'b1, 1'b0, 10'h008};
      tbl[5] = '{10'h000, 1'b1, 1'b0, 10'h008, 4'd3, 1'b0, 1'b1, 10'h000};
      tbl[6] = '{10'h000, 1'b0, 1'b1, 10'h000, 4'd3, 1'b0, 1'b0, 10'h000};

      #1;
      do_reset("t1");
      step('0, 1'b0, 1'b0, "t1.idle");

      // Two simultaneous pulses served highest first.
      for (int k = 0; k < 7; k++) begin
         step(tbl[k].req, tbl[k].rdy, tbl[k].dn, $sformatf("t2.m%0d", k));
         check($sformatf("t2.v%0d.onehot", k),  32'(gnt_onehot), 32'(tbl[k].oh));
         check($sformatf("t2.v%0d.idx", k),     32'(gnt_idx), 32'(tbl[k].idx));
         check($sformatf("t2.v%0d.valid", k),   32'(gnt_valid), 32'(tbl[k].v));
         check($sformatf("t2.v%0d.busy", k),    32'(busy), 32'(tbl[k].b));
         check($sformatf("t2.v%0d.pending", k), 32'(pending), 32'(tbl[k].pend));
      end

      // Stalled offer is frozen even when a higher client arrives.
      step(10'h080, 1'b0, 1'b0, "t3");
      step('0, 1'b0, 1'b0, "t3");
      for (int k = 0; k < 5; k++) begin
         step((k == 1) ? 10'h200 : 10'h000, 1'b0, 1'b0, "t3.stall");
         check($sformatf("t3.frozen%0d", k), 32'(gnt_onehot), 32'h080);
      end
      step('0, 1'b1, 1'b0, "t3.acc");
      step('0, 1'b0, 1'b1, "t3.done");
      step('0, 1'b0, 1'b0, "t3.next");
      check("t3.next_grant", 32'(gnt_onehot), 32'h200);
      step('0, 1'b1, 1'b0, "t3");
      step('0, 1'b0, 1'b1, "t3");

      // Re-request on the accept edge and during ownership is retained.
      step(10'h020, 1'b0, 1'b0, "t4");
      step('0, 1'b0, 1'b0, "t4");
      step(10'h020, 1'b1, 1'b0, "t4.acc");
      check("t4.pend5_kept", 32'(pending[5]), 32'd1);
      step(10'h020, 1'b0, 1'b0, "t4.busy");
      step('0, 1'b0, 1'b1, "t4.done");
      step('0, 1'b0, 1'b0, "t4.regrant");
      check("t4.regrant_idx", 32'(gnt_idx), 32'd5);
      check("t4.regrant_valid", 32'(gnt_valid), 32'd1);
      step('0, 1'b1, 1'b0, "t4");
      step('0, 1'b0, 1'b1, "t4");

      // Persistent requesters 9 and 2.
      do_reset("t5.rst");
      prev_busy = 1'b0;
      for (int c = 0; c < 40 && got.size() < 4; c++) begin
         step(10'h204, 1'b1, 1'b1, "t5");
         if (busy && !prev_busy) got.push_back(int'(gnt_idx));
         prev_busy = busy;
      end
      check("t5.grant_count", 32'(got.size()), 32'd4);
      exp_seq = RR ? '{9, 2, 9, 2} : '{9, 9, 9, 9};
      for (int k = 0; k < 4 && k < got.size(); k++)
         check($sformatf("t5.grant%0d", k), 32'(got[k]), 32'(exp_seq[k]));

      // Asynchronous reset while owned, done held low.
      do_reset("t6.pre");
      step(10'h008, 1'b0, 1'b0, "t6");
      step('0, 1'b0, 1'b0, "t6");
      step('0, 1'b1, 1'b0, "t6");
      step('0, 1'b0, 1'b0, "t6.busy");
      check("t6.was_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("t6.midcycle");
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) step('0, 1'b1, 1'b1, "t6.quiet");
      step(10'h002, 1'b0, 1'b0, "t6.new");
      step('0, 1'b0, 1'b0, "t6.new");
      check("t6.new_grant", 32'(gnt_onehot), 32'h002);

      // Random traffic against the model, with occasional resets.
      for (int k = 0; k < 1500; k++) begin
         if (k % 400 == 399) do_reset("rnd.rst");
         step(($urandom_range(0, 3) == 0) ? N'($urandom) : N'(0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
